data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the core's data-memory port: accepts one load/store request at a time
//  over a valid/ready handshake, performs the access after a fixed latency, and returns a response
//  over a second valid/ready handshake. Sits between the core's load/store path and word storage.
//  Enables multi-cycle memory timing and error reporting that the single-cycle core's memory lacks.
// PARAMETERS
//  DEPTH_WORDS  512  number of 32-bit words; valid byte addresses 0 .. 4*DEPTH_WORDS-1
//  LATENCY      2    edges from request accept to resp_valid rising; legal range 1..15
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept a request (state IDLE)
//  req_write   in   1   1 = store, 0 = load
//  req_addr    in   32  byte address; word index = req_addr[31:2]
//  req_wdata   in   32  store data
//  req_be      in   4   store byte enables; bit i writes byte i = wdata[8i+7:8i]
//  resp_valid  out  1   response present
//  resp_ready  in   1   requester consumes response
//  resp_rdata  out  32  load data; 0 for stores and for errors
//  resp_err    out  1   1 = misaligned or out-of-range access
// BEHAVIOUR
//  - Reset: synchronous; on any edge with rst=1: state=IDLE, resp_valid=0, resp_rdata=0,
//    resp_err=0, latency counter=0. req_ready=0 while rst=1. Memory array is NOT cleared;
//    contents survive reset.
//  - FSM: IDLE -> WAIT -> RESP -> IDLE.
//  - IDLE: req_ready = 1. If req_valid=1 on an edge, the request is accepted at that edge (E0):
//    write, addr, wdata and be are captured; counter loaded with LATENCY-1; go to WAIT.
//  - WAIT: req_ready = 0; counter decrements each edge. On the edge where the counter is 0
//    (edge E0+LATENCY), the access executes, resp_valid=1 and the state goes to RESP.
//  - Access at edge E0+LATENCY:
//    - Error if addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS. Then resp_err=1, resp_rdata=0
//      and memory is unchanged.
//    - Store: write only the bytes enabled by be; resp_rdata=0. be=0000 is legal (no change).
//    - Load: resp_rdata = mem[addr[31:2]] (full word, be ignored).
//  - RESP: resp_valid, resp_rdata and resp_err hold stable until an edge with resp_ready=1.
//    At that edge resp_valid becomes 0 and the state goes to IDLE. resp_rdata/resp_err keep
//    their last values.
//  - Throughput: one request per LATENCY+2 edges minimum. The earliest next accept is edge
//    E0+LATENCY+2, when resp_ready=1 during RESP.
//  - Request fields are ignored outside IDLE. The requester may drop req_valid with no effect
//    on an in-flight access.
//  - Reset mid-operation: rst=1 on or before edge E0+LATENCY aborts the request. No memory
//    write occurs and no response is issued. Reset in RESP discards the pending response.
//  - Simultaneous rst and req_valid: reset wins and the request is not accepted.
// TESTING
//  T1 reset: hold rst 2 cycles -> req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0;
//     the cycle after release, req_ready=1.
//  T2 store/load, LATENCY=2: store addr 0x10, data 0xDEADBEEF, be=1111, accepted E0 ->
//     resp_valid rises at E2, err=0. Load 0x10 -> resp_rdata=0xDEADBEEF at E0+2.
//  T3 byte enables: mem[0x20]=0x11223344, store 0xAABBCCDD be=0101 -> load 0x20 returns 0x11BB33DD.
//  T4 errors: load 0x22 -> err=1, rdata=0. Store 0x800 (DEPTH 512) -> err=1 and no word changes.
//     Load 0x7FC -> err=0.
//  T5 backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready=0.
//     Raise resp_ready -> IDLE next edge, next accept 1 edge later.
//  T6 reset mid-WAIT: store 0x55 to 0x40 (old 0x0) with rst pulsed at E0+1 -> no response and
//     load 0x40 returns 0x0. Repeat with LATENCY=1: resp_valid rises at E0+1.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency load/store responder for the data-memory port
module data_mem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic             cap_write;
  logic [31:0]      cap_addr;
  logic [31:0]      cap_wdata;
  logic [3:0]       cap_be;
  logic             accept;
  logic             exec;
  logic             acc_err;
  logic [IDX_W-1:0] idx;
  logic [31:0]      mem [DEPTH_WORDS];

  assign acc_err = (cap_addr[1:0] != 2'b00) ||
                   ({2'b00, cap_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign idx     = cap_addr[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    exec      = 1'b0;
    case (state)
      IDLE: begin
        // Reset has priority over a simultaneous request.
        req_ready = !rst;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          exec      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_write <= req_write;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_be    <= req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (exec) begin
        resp_valid <= 1'b1;
        resp_err   <= acc_err;
        resp_rdata <= (acc_err || cap_write) ? 32'd0 : mem[idx];
      end else if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  // Storage is never reset; a reset arriving on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (exec && !rst && !acc_err && cap_write) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_be[i]) mem[idx][8*i +: 8] <= cap_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench with reference memory model for data_mem_responder
module tb_data_mem_responder;

  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_ready;

  logic        rr0, rr1, rv0, rv1, re0, re1;
  logic [31:0] rd0, rd1;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          rise;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [2][DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        prev_v = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel), .req_ready(rr0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv0), .resp_ready(resp_ready && !sel), .resp_rdata(rd0), .resp_err(re0)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel), .req_ready(rr1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv1), .resp_ready(resp_ready && sel), .resp_rdata(rd1), .resp_err(re1)
  );

  assign req_ready  = sel ? rr1 : rr0;
  assign resp_valid = sel ? rv1 : rv0;
  assign resp_rdata = sel ? rd1 : rd0;
  assign resp_err   = sel ? re1 : re0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: word-addressed array, bytes merged by enable, errors leave it untouched.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err);
    int inst;
    int wi;
    inst  = sel ? 1 : 0;
    err   = (a % 4 != 0) || (a / 4 >= DEPTH);
    rdata = 32'd0;
    if (!err) begin
      wi = int'(a / 4);
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[inst][wi][8*b +: 8] = d[8*b +: 8];
      end else begin
        rdata = ref_mem[inst][wi];
      end
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp got valid=1 exp valid=0 (cycle %0d)", cyc);
      end else begin
        if (!prev_v) chk("latency", 32'(cyc), 32'(sb[0].rise));
        chk("rdata", resp_rdata, sb[0].rdata);
        chk("err", 32'(resp_err), 32'(sb[0].err));
        if (resp_ready) void'(sb.pop_front());
      end
    end
    prev_v = resp_valid;
  end

  task automatic transact(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input int hold, input bit turn_chk);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    resp_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout got req_ready=0 exp 1");
      req_valid = 1'b0;
      return;
    end
    model(w, a, d, be, e.rdata, e.err);
    e.rise = cyc + 1 + (sel ? 1 : 2);
    sb.push_back(e);
    @(posedge clk); #1;
    // Request lines are ignored outside IDLE; scramble them.
    req_valid = 1'($urandom_range(0, 1));
    req_write = 1'($urandom_range(0, 1));
    req_addr  = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 40) begin @(negedge clk); n++; end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout got resp_valid=0 exp 1");
      sb.delete();
      req_valid = 1'b0;
      return;
    end
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("req_ready_hold", 32'(req_ready), 32'd0);
      chk("resp_valid_hold", 32'(resp_valid), 32'd1);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    if (turn_chk) begin
      @(negedge clk);
      chk("turn_resp_valid", 32'(resp_valid), 32'd0);
      chk("turn_req_ready", 32'(req_ready), 32'd1);
    end
  endtask

  task automatic abort_store(input logic [31:0] a, input logic [31:0] d);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_be = 4'hF;
    resp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; resp_ready = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    chk("abort_no_resp", 32'(n), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0: a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      1: a = $urandom | 32'h0000_0800;
      2: a = ($urandom_range(0, 1) != 0) ? 32'h7FC : 32'h800;
      default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
    endcase
    return a;
  endfunction

  initial begin
    int n;
    rst = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < DEPTH; i++) transact(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0);

    transact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    transact(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    transact(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0);
    transact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, 1'b0);
    transact(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);
    chk("byte_merge_model", ref_mem[0][8], 32'h11BB33DD);
    transact(1'b1, 32'h24, 32'hCAFEF00D, 4'b0000, 0, 1'b0);
    transact(1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0);
    transact(1'b0, 32'h22, 32'h0, 4'h0, 0, 1'b0);
    transact(1'b1, 32'h800, 32'h12345678, 4'hF, 0, 1'b0);
    transact(1'b0, 32'h7FC, 32'h0, 4'h0, 0, 1'b0);
    transact(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1);

    transact(1'b1, 32'h40, 32'h0, 4'hF, 0, 1'b0);
    abort_store(32'h40, 32'h55);
    transact(1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0);

    for (int i = 0; i < 300; i++)
      transact(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    for (int i = 0; i < DEPTH; i += 37) transact(1'b0, 32'(i * 4), 32'h0, 4'h0, 0, 1'b0);

    sel = 1'b1;
    for (int i = 16; i < 20; i++) transact(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0);
    transact(1'b1, 32'h40, 32'h0, 4'hF, 0, 1'b0);
    abort_store(32'h40, 32'h55);
    transact(1'b0, 32'h40, 32'h0, 4'h0, 2, 1'b1);
    for (int i = 0; i < 40; i++)
      transact(1'($urandom_range(0, 1)), 32'($urandom_range(16, 19)) << 2, $urandom,
               4'($urandom), $urandom_range(0, 2), 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
